// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker: FSM encoding and a
// constant-width helper.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// Settle timer: loadable down-counter. expire is high while the count is zero,
// so a load of SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES enabled cycles.
module settle_timer
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = (clog2(SETTLE_CYCLES) < 1) ? 1 : clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Self-test engine: sweeps all input vectors onto a gate under test, samples its
// output after a settle time and records per-vector mismatches against EXPECTED.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start, all results zero
// ST_APPLY  | a_out driven with vec, settle timer running
// ST_SAMPLE | one cycle; y_in compared with EXPECTED[vec] at its closing edge
// ST_DONE   | sweep complete, results and pass held until next start
module gate_truth_table_checker
    import gate_chk_pkg::*;
#(
    parameter int                      N_IN          = 2,
    parameter logic [(2**N_IN)-1:0]    EXPECTED      = 4'b1001,
    parameter int                      SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   y_in,
    output logic [N_IN-1:0]        a_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   fail_vec,
    output logic [N_IN:0]          err_count
);

    localparam int NV = 2**N_IN;

    state_t state;
    logic   timer_load;
    logic   timer_en;
    logic   expire;
    logic   last_vec;
    logic   mismatch;

    assign last_vec = &a_out;
    // Case inequality so an undriven or X gate output is reported as a failure.
    assign mismatch = (y_in !== EXPECTED[a_out]);

    assign timer_load = (((state == ST_IDLE) || (state == ST_DONE)) && start) ||
                        ((state == ST_SAMPLE) && !last_vec);
    assign timer_en   = (state == ST_APPLY);

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .en     (timer_en),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            err_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_APPLY;
                        a_out     <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_vec  <= '0;
                        err_count <= '0;
                    end
                end
                ST_APPLY: begin
                    if (expire) state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        fail_vec[a_out] <= 1'b1;
                        err_count       <= err_count + 1'b1;
                    end
                    if (last_vec) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Final vector's result is not yet in fail_vec, fold it in here.
                        pass  <= !mismatch && (fail_vec == '0);
                    end else begin
                        state <= ST_APPLY;
                        a_out <= a_out + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
